// File: rtl/mm_sched.sv
// Tiling command scheduler for the mm matrix-vector engine.
// Latency: accept -> mm start next cycle; mm_done -> next start after GAP_CYCLES, or cmd_done next cycle.
// Backpressure: cmd_ready is high only in IDLE; one command is in flight at a time.
module mm_sched #(
  parameter int TILE_NODES     = 64,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [12:0] cmd_weight_addr,
  input  logic [10:0] cmd_input_addr,
  input  logic [10:0] cmd_output_addr,
  input  logic [7:0]  cmd_ci,
  input  logic [7:0]  cmd_co,
  input  logic [15:0] cmd_n,
  output logic        mm_start_valid,
  output logic [12:0] mm_weight_start_addr,
  output logic [10:0] mm_input_start_addr,
  output logic [10:0] mm_output_start_addr,
  output logic [7:0]  mm_input_addr_per_feature,
  output logic [7:0]  mm_output_addr_per_feature,
  output logic [15:0] mm_number_of_node,
  input  logic        mm_done,
  output logic        busy,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic [15:0] tile_idx
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_FIN} state_t;

  localparam logic [15:0] TILE_W   = 16'(TILE_NODES);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        rdy_en_q;
  logic [12:0] w_q, w_d;
  logic [7:0]  ci_q, ci_d, co_q, co_d;
  logic [15:0] rem_q, rem_d;
  logic [10:0] in_ptr_q, in_ptr_d, out_ptr_q, out_ptr_d;
  logic [31:0] wd_q, wd_d, gap_q, gap_d;
  logic [15:0] tile_idx_q, tile_idx_d;
  logic        err_q, err_d;
  logic [12:0] mm_w_q, mm_w_d;
  logic [10:0] mm_in_q, mm_in_d, mm_out_q, mm_out_d;
  logic [7:0]  mm_ci_q, mm_ci_d, mm_co_q, mm_co_d;
  logic [15:0] mm_n_q, mm_n_d;
  logic [23:0] in_adv, out_adv;

  // Pointer advance for the tile just completed; only the low 11 bits matter (wrap mod 2048).
  assign in_adv  = ci_q * mm_n_q;
  assign out_adv = co_q * mm_n_q;

  assign cmd_ready      = rdy_en_q && (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign cmd_done       = (state_q == S_FIN);
  assign mm_start_valid = (state_q == S_ISSUE);
  assign cmd_err        = err_q;
  assign tile_idx       = tile_idx_q;

  assign mm_weight_start_addr       = mm_w_q;
  assign mm_input_start_addr        = mm_in_q;
  assign mm_output_start_addr       = mm_out_q;
  assign mm_input_addr_per_feature  = mm_ci_q;
  assign mm_output_addr_per_feature = mm_co_q;
  assign mm_number_of_node          = mm_n_q;

  // Next-state and datapath updates; mm_* config is reloaded only on entry to ISSUE.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    ci_d       = ci_q;
    co_d       = co_q;
    rem_d      = rem_q;
    in_ptr_d   = in_ptr_q;
    out_ptr_d  = out_ptr_q;
    wd_d       = wd_q;
    gap_d      = gap_q;
    tile_idx_d = tile_idx_q;
    err_d      = err_q;
    mm_w_d     = mm_w_q;
    mm_in_d    = mm_in_q;
    mm_out_d   = mm_out_q;
    mm_ci_d    = mm_ci_q;
    mm_co_d    = mm_co_q;
    mm_n_d     = mm_n_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_d        = cmd_weight_addr;
          ci_d       = cmd_ci;
          co_d       = cmd_co;
          in_ptr_d   = cmd_input_addr;
          out_ptr_d  = cmd_output_addr;
          err_d      = 1'b0;
          tile_idx_d = 16'd0;
          if (cmd_n == 16'd0 || cmd_ci == 8'd0 || cmd_co == 8'd0) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            rem_d   = cmd_n;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = 32'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the expiry cycle still counts as success.
        if (mm_done) begin
          rem_d     = rem_q - mm_n_q;
          in_ptr_d  = in_ptr_q + in_adv[10:0];
          out_ptr_d = out_ptr_q + out_adv[10:0];
          if (rem_d == 16'd0) begin
            state_d = S_FIN;
          end else begin
            tile_idx_d = tile_idx_q + 16'd1;
            gap_d      = 32'd0;
            state_d    = S_GAP;
          end
        end else if (wd_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_ISSUE;
        else                   gap_d   = gap_q + 32'd1;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ISSUE) begin
      mm_w_d   = w_d;
      mm_in_d  = in_ptr_d;
      mm_out_d = out_ptr_d;
      mm_ci_d  = ci_d;
      mm_co_d  = co_d;
      mm_n_d   = (rem_d > TILE_W) ? TILE_W : rem_d;
    end
  end

  // State and datapath registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rdy_en_q   <= 1'b0;
      w_q        <= '0;
      ci_q       <= '0;
      co_q       <= '0;
      rem_q      <= '0;
      in_ptr_q   <= '0;
      out_ptr_q  <= '0;
      wd_q       <= '0;
      gap_q      <= '0;
      tile_idx_q <= '0;
      err_q      <= 1'b0;
      mm_w_q     <= '0;
      mm_in_q    <= '0;
      mm_out_q   <= '0;
      mm_ci_q    <= '0;
      mm_co_q    <= '0;
      mm_n_q     <= '0;
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      w_q        <= w_d;
      ci_q       <= ci_d;
      co_q       <= co_d;
      rem_q      <= rem_d;
      in_ptr_q   <= in_ptr_d;
      out_ptr_q  <= out_ptr_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      tile_idx_q <= tile_idx_d;
      err_q      <= err_d;
      mm_w_q     <= mm_w_d;
      mm_in_q    <= mm_in_d;
      mm_out_q   <= mm_out_d;
      mm_ci_q    <= mm_ci_d;
      mm_co_q    <= mm_co_d;
      mm_n_q     <= mm_n_d;
    end
  end

endmodule

// File: tb/tb_mm_sched.sv
// Directed bench for mm_sched: tiling, pointer wrap, degenerate commands, watchdog, reset.
// Inputs driven and outputs sampled 1ns after each rising edge.
// The bench plays the mm engine, pulsing mm_done after fixed delays.
module tb_mm_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [12:0] cmd_weight_addr;
  logic [10:0] cmd_input_addr, cmd_output_addr;
  logic [7:0]  cmd_ci, cmd_co;
  logic [15:0] cmd_n;
  logic        mm_start_valid;
  logic [12:0] mm_weight_start_addr;
  logic [10:0] mm_input_start_addr, mm_output_start_addr;
  logic [7:0]  mm_input_addr_per_feature, mm_output_addr_per_feature;
  logic [15:0] mm_number_of_node;
  logic        mm_done;
  logic        busy, cmd_done, cmd_err;
  logic [15:0] tile_idx;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] e_ci, e_co;

  always #5 clk = ~clk;

  mm_sched #(.TILE_NODES(64), .GAP_CYCLES(2), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_weight_addr(cmd_weight_addr), .cmd_input_addr(cmd_input_addr),
    .cmd_output_addr(cmd_output_addr), .cmd_ci(cmd_ci), .cmd_co(cmd_co), .cmd_n(cmd_n),
    .mm_start_valid(mm_start_valid), .mm_weight_start_addr(mm_weight_start_addr),
    .mm_input_start_addr(mm_input_start_addr), .mm_output_start_addr(mm_output_start_addr),
    .mm_input_addr_per_feature(mm_input_addr_per_feature),
    .mm_output_addr_per_feature(mm_output_addr_per_feature),
    .mm_number_of_node(mm_number_of_node), .mm_done(mm_done),
    .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err), .tile_idx(tile_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single cycle; afterwards the bench sits in cycle k+1.
  task automatic send_cmd(input logic [12:0] w, input logic [10:0] i, input logic [10:0] o,
                          input logic [7:0] ci, input logic [7:0] co, input logic [15:0] n);
    cmd_weight_addr = w; cmd_input_addr = i; cmd_output_addr = o;
    cmd_ci = ci; cmd_co = co; cmd_n = n;
    e_ci = ci; e_co = co;
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called in the expected ISSUE cycle; answers with mm_done after 'delay' WAIT cycles.
  task automatic run_tile(input string tag, input logic [15:0] n, input logic [10:0] i,
                          input logic [10:0] o, input logic [12:0] w, input int delay,
                          input bit last);
    check({tag, "_start"}, 32'(mm_start_valid), 32'd1);
    check({tag, "_n"},     32'(mm_number_of_node), 32'(n));
    check({tag, "_in"},    32'(mm_input_start_addr), 32'(i));
    check({tag, "_out"},   32'(mm_output_start_addr), 32'(o));
    check({tag, "_w"},     32'(mm_weight_start_addr), 32'(w));
    check({tag, "_ci_co"}, {16'd0, mm_input_addr_per_feature, mm_output_addr_per_feature},
          {16'd0, e_ci, e_co});
    repeat (delay) tick();
    check({tag, "_wait_nostart"}, 32'(mm_start_valid), 32'd0);
    check({tag, "_wait_hold_in"}, 32'(mm_input_start_addr), 32'(i));
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    if (last) begin
      check({tag, "_cmd_done"}, 32'(cmd_done), 32'd1);
      tick();
      check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    end else begin
      check({tag, "_no_done"}, 32'(cmd_done), 32'd0);
      // Spurious done in the first GAP cycle must be ignored.
      mm_done = 1'b1;
      check({tag, "_gap0"}, 32'(mm_start_valid), 32'd0);
      tick();
      mm_done = 1'b0;
      check({tag, "_gap1"}, 32'(mm_start_valid), 32'd0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; mm_done = 1'b0;
    cmd_weight_addr = '0; cmd_input_addr = '0; cmd_output_addr = '0;
    cmd_ci = '0; cmd_co = '0; cmd_n = '0; e_ci = '0; e_co = '0;
    #12;
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_outs", {busy, cmd_done, cmd_err, mm_start_valid}, 32'd0);
    check("rst_n", 32'(mm_number_of_node), 32'd0);
    rstn = 1'b1;
    tick();
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Spurious done in IDLE does nothing.
    mm_done = 1'b1; tick(); mm_done = 1'b0;
    check("idle_spurious_busy", 32'(busy), 32'd0);

    // Single tile.
    send_cmd(13'h100, 11'h010, 11'h020, 8'd2, 8'd3, 16'd10);
    check("t1_busy", 32'(busy), 32'd1);
    run_tile("t1", 16'd10, 11'h010, 11'h020, 13'h100, 40, 1'b1);
    check("t1_err", 32'(cmd_err), 32'd0);
    check("t1_tile_idx", 32'(tile_idx), 32'd0);

    // Three tiles 64/64/22.
    send_cmd(13'h055, 11'h000, 11'h000, 8'd4, 8'd2, 16'd150);
    run_tile("t2a", 16'd64, 11'd0,   11'd0,   13'h055, 5, 1'b0);
    check("t2_idx1", 32'(tile_idx), 32'd1);
    run_tile("t2b", 16'd64, 11'd256, 11'd128, 13'h055, 7, 1'b0);
    run_tile("t2c", 16'd22, 11'd512, 11'd256, 13'h055, 3, 1'b1);
    check("t2_tile_idx", 32'(tile_idx), 32'd2);
    check("t2_err", 32'(cmd_err), 32'd0);

    // Pointer wrap: 0x7F0 + 4*64 -> 0x0F0, 0x7FF + 1*64 -> 0x03F.
    send_cmd(13'h1FFF, 11'h7F0, 11'h7FF, 8'd4, 8'd1, 16'd80);
    run_tile("wr_a", 16'd64, 11'h7F0, 11'h7FF, 13'h1FFF, 2, 1'b0);
    run_tile("wr_b", 16'd16, 11'h0F0, 11'h03F, 13'h1FFF, 2, 1'b1);
    check("wr_tile_idx", 32'(tile_idx), 32'd1);

    // Degenerate commands: N=0, Ci=0, Co=0.
    for (int d = 0; d < 3; d++) begin
      send_cmd(13'h001, 11'h001, 11'h001, (d == 1) ? 8'd0 : 8'd1,
               (d == 2) ? 8'd0 : 8'd1, (d == 0) ? 16'd0 : 16'd5);
      check($sformatf("deg%0d_done", d), 32'(cmd_done), 32'd1);
      check($sformatf("deg%0d_err", d), 32'(cmd_err), 32'd1);
      check($sformatf("deg%0d_nostart", d), 32'(mm_start_valid), 32'd0);
      tick();
      check($sformatf("deg%0d_idle", d), {cmd_ready, busy, cmd_err}, 32'b101);
    end

    // Watchdog expiry: done withheld, abort after wd reaches 99.
    send_cmd(13'h002, 11'h004, 11'h008, 8'd1, 8'd1, 16'd5);
    check("to_start", 32'(mm_start_valid), 32'd1);
    check("to_err_cleared", 32'(cmd_err), 32'd0);
    repeat (100) tick();
    check("to_not_yet", 32'(cmd_done), 32'd0);
    tick();
    check("to_done", 32'(cmd_done), 32'd1);
    check("to_err", 32'(cmd_err), 32'd1);
    tick();
    check("to_err_sticky", {cmd_ready, cmd_err}, 32'b11);

    // Done on the expiry cycle wins.
    send_cmd(13'h002, 11'h004, 11'h008, 8'd1, 8'd1, 16'd5);
    repeat (100) tick();
    mm_done = 1'b1; tick(); mm_done = 1'b0;
    check("tov_done", 32'(cmd_done), 32'd1);
    check("tov_err", 32'(cmd_err), 32'd0);
    tick();

    // Reset during WAIT of tile 2.
    send_cmd(13'h055, 11'h000, 11'h000, 8'd4, 8'd2, 16'd150);
    run_tile("rs_a", 16'd64, 11'd0,   11'd0,   13'h055, 4, 1'b0);
    run_tile("rs_b", 16'd64, 11'd256, 11'd128, 13'h055, 4, 1'b0);
    check("rs_issue_c", 32'(mm_start_valid), 32'd1);
    tick(); tick();
    rstn = 1'b0;
    #1;
    check("rs_ready", 32'(cmd_ready), 32'd0);
    check("rs_flags", {busy, cmd_done, cmd_err, mm_start_valid}, 32'd0);
    check("rs_cfg", {mm_number_of_node, 5'd0, mm_input_start_addr}, 32'd0);
    check("rs_tile_idx", 32'(tile_idx), 32'd0);
    #1;
    rstn = 1'b1;
    tick();
    check("rs_ready_back", 32'(cmd_ready), 32'd1);
    check("rs_no_done", 32'(cmd_done), 32'd0);
    send_cmd(13'h100, 11'h010, 11'h020, 8'd2, 8'd3, 16'd10);
    run_tile("rs_new", 16'd10, 11'h010, 11'h020, 13'h100, 6, 1'b1);
    check("rs_new_err", 32'(cmd_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
